// File: rtl/frame_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scan_driver
//  Description : Scans a static ROWS x COLS monochrome bitmap row by row and
//                serialises each row onto a shift-register display: serial
//                clock, serial data, row latch strobe and row address.
//                frame[r] is row r; bit n of a row is pixel column n, and
//                bit 0 (the leftmost pixel) is shifted out first.
//                Define SCAN_LOOP_EN to rescan continuously after one start.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_scan_driver #(
    parameter int ROWS    = 40,
    parameter int COLS    = 256,
    parameter int CLK_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [0:ROWS-1][COLS-1:0] frame,
    output logic                      busy,
    output logic                      done,
    output logic                      sclk,
    output logic                      sdata,
    output logic                      row_latch,
    output logic [$clog2(ROWS)-1:0]   row_addr
);

    localparam int c_RA_W  = $clog2(ROWS);
    localparam int c_BIT_W = $clog2(COLS + 1);
    localparam int c_IDX_W = $clog2(COLS);
    localparam int c_DIV_W = $clog2(2 * CLK_DIV);

    localparam logic [c_RA_W-1:0]  c_LAST_ROW = c_RA_W'(ROWS - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(COLS - 1);
    localparam logic [c_DIV_W-1:0] c_LAST_DIV = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_HALF_DIV = c_DIV_W'(CLK_DIV);

`ifdef SCAN_LOOP_EN
    localparam logic c_LOOP_EN = 1'b1;
`else
    localparam logic c_LOOP_EN = 1'b0;
`endif

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_LATCH = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [COLS-1:0]    r_row_buf;
    logic [c_BIT_W-1:0] r_bit;
    logic [c_DIV_W-1:0] r_div;

    logic [c_BIT_W-1:0] w_bit_next;
    logic [c_IDX_W-1:0] w_bit_idx;
    logic [c_DIV_W-1:0] w_div_next;

    assign w_bit_next = r_bit + 1'b1;
    assign w_bit_idx  = w_bit_next[c_IDX_W-1:0];
    assign w_div_next = r_div + 1'b1;

    // Scan sequencer: state, bit/divider counters, row buffer and all outputs.
    // Outputs are registered with the value they must hold in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_row_buf <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            row_latch <= 1'b0;
            row_addr  <= '0;
        end else begin
            row_latch <= 1'b0;
            done      <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    busy     <= 1'b0;
                    sclk     <= 1'b0;
                    sdata    <= 1'b0;
                    row_addr <= '0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    // The first bit period starts next cycle, so its data
                    // comes straight from the frame rather than the buffer.
                    r_row_buf <= frame[row_addr];
                    r_bit     <= '0;
                    r_div     <= '0;
                    sclk      <= 1'b0;
                    sdata     <= frame[row_addr][0];
                    r_state   <= c_ST_SHIFT;
                end
                c_ST_SHIFT: begin
                    if (r_div == c_LAST_DIV) begin
                        r_div <= '0;
                        sclk  <= 1'b0;
                        if (r_bit == c_LAST_BIT) begin
                            sdata     <= 1'b0;
                            row_latch <= 1'b1;
                            r_state   <= c_ST_LATCH;
                        end else begin
                            r_bit <= w_bit_next;
                            sdata <= r_row_buf[w_bit_idx];
                        end
                    end else begin
                        r_div <= w_div_next;
                        sclk  <= (w_div_next >= c_HALF_DIV);
                    end
                end
                c_ST_LATCH: begin
                    if (row_addr == c_LAST_ROW) begin
                        done     <= 1'b1;
                        busy     <= c_LOOP_EN;
                        row_addr <= '0;
                        r_state  <= c_ST_DONE;
                    end else begin
                        row_addr <= row_addr + 1'b1;
                        r_state  <= c_ST_LOAD;
                    end
                end
                c_ST_DONE: begin
                    busy <= c_LOOP_EN;
                    if (c_LOOP_EN) begin
                        r_state <= c_ST_LOAD;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scan_driver
//  Description : Self-checking bench for frame_scan_driver. A small instance
//                (2 rows x 8 columns, divide-by-1) and a default-sized
//                instance run side by side against a cycle-position model.
//                Honours SCAN_LOOP_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scan_driver;

`ifdef SCAN_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int S_ROWS = 2;
    localparam int S_COLS = 8;
    localparam int S_DIV  = 1;
    localparam int S_P    = 2 + 2 * S_COLS * S_DIV;
    localparam int S_D    = S_ROWS * S_P;
    localparam int B_ROWS = 40;
    localparam int B_COLS = 256;
    localparam int B_DIV  = 4;
    localparam int B_P    = 2 + 2 * B_COLS * B_DIV;
    localparam int B_D    = B_ROWS * B_P;
    localparam int NDONE  = LOOP ? 2 : 1;

    typedef struct {
        logic busy;
        logic done;
        logic sclk;
        logic lat;
        logic load;
        int   row;
        int   bitn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance
    logic                      s_rst, s_start;
    logic [0:S_ROWS-1][S_COLS-1:0] s_frame;
    logic                      s_busy, s_done, s_sclk, s_sdata, s_latch;
    logic [0:0]                s_row;
    // default instance
    logic                      b_rst, b_start;
    logic [0:B_ROWS-1][B_COLS-1:0] b_frame;
    logic                      b_busy, b_done, b_sclk, b_sdata, b_latch;
    logic [5:0]                b_row;

    frame_scan_driver #(.ROWS(S_ROWS), .COLS(S_COLS), .CLK_DIV(S_DIV)) u_small (
        .clk(clk), .rst(s_rst), .start(s_start), .frame(s_frame),
        .busy(s_busy), .done(s_done), .sclk(s_sclk), .sdata(s_sdata),
        .row_latch(s_latch), .row_addr(s_row)
    );

    frame_scan_driver u_big (
        .clk(clk), .rst(b_rst), .start(b_start), .frame(b_frame),
        .busy(b_busy), .done(b_done), .sclk(b_sclk), .sdata(b_sdata),
        .row_latch(b_latch), .row_addr(b_row)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: scan position as cycles elapsed since the start edge.
    bit s_act = 0;
    int s_t   = 0;
    bit b_act = 0;
    int b_t   = 0;
    logic [S_COLS-1:0] s_snap [0:S_ROWS-1];
    logic [B_COLS-1:0] b_snap [0:B_ROWS-1];

    function automatic exp_t calc(input int t, input int rows, input int cols,
                                  input int div, input bit act);
        exp_t e;
        int p, d, o, s;
        e.busy = 0; e.done = 0; e.sclk = 0; e.lat = 0; e.load = 0;
        e.row = 0; e.bitn = -1;
        if (!act) return e;
        p = 2 + 2 * cols * div;
        d = rows * p;
        e.busy = 1;
        if (t == d) begin
            e.done = 1;
            e.busy = LOOP;
            return e;
        end
        e.row = t / p;
        o = t % p;
        if (o == 0) e.load = 1;
        else if (o == p - 1) e.lat = 1;
        else begin
            s = o - 1;
            e.bitn = s / (2 * div);
            e.sclk = (s % (2 * div)) >= div;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (s_rst) begin s_act = 0; s_t = 0; end
        else if (!s_act) begin if (s_start) begin s_act = 1; s_t = 0; end end
        else if (s_t == S_D) begin if (LOOP) s_t = 0; else s_act = 0; end
        else s_t++;
        if (b_rst) begin b_act = 0; b_t = 0; end
        else if (!b_act) begin if (b_start) begin b_act = 1; b_t = 0; end end
        else if (b_t == B_D) begin if (LOOP) b_t = 0; else b_act = 0; end
        else b_t++;
    end

    // Per-cycle compare, small instance
    always @(negedge clk) begin : cmp_small
        exp_t e;
        logic sd;
        e = calc(s_t, S_ROWS, S_COLS, S_DIV, s_act);
        if (e.load) s_snap[e.row] = s_frame[e.row];
        sd = (e.bitn >= 0) ? s_snap[e.row][e.bitn] : 1'b0;
        n_vec++;
        if ({s_busy, s_done, s_sclk, s_sdata, s_latch} !== {e.busy, e.done, e.sclk, sd, e.lat}
            || s_row !== 1'(e.row)) begin
            n_err++;
            $display("FAIL small_cycle@%0d t=%0d: got busy/done/sclk/sdata/latch=%b row=%0d, expected %b row=%0d",
                     cyc, s_t, {s_busy, s_done, s_sclk, s_sdata, s_latch}, s_row,
                     {e.busy, e.done, e.sclk, sd, e.lat}, e.row);
        end
    end

    // Per-cycle compare, default instance
    always @(negedge clk) begin : cmp_big
        exp_t e;
        logic sd;
        e = calc(b_t, B_ROWS, B_COLS, B_DIV, b_act);
        if (e.load) b_snap[e.row] = b_frame[e.row];
        sd = (e.bitn >= 0) ? b_snap[e.row][e.bitn] : 1'b0;
        n_vec++;
        if ({b_busy, b_done, b_sclk, b_sdata, b_latch} !== {e.busy, e.done, e.sclk, sd, e.lat}
            || b_row !== 6'(e.row)) begin
            n_err++;
            $display("FAIL big_cycle@%0d t=%0d: got busy/done/sclk/sdata/latch=%b row=%0d, expected %b row=%0d",
                     cyc, b_t, {b_busy, b_done, b_sclk, b_sdata, b_latch}, b_row,
                     {e.busy, e.done, e.sclk, sd, e.lat}, e.row);
        end
    end

    // Display-side observers
    logic s_sclk_prev = 0;
    logic s_rise_q[$];
    int   s_lat_q[$];
    int   s_done_q[$];
    int   s_busy_low = 0;
    always @(negedge clk) begin
        if (s_sclk && !s_sclk_prev) s_rise_q.push_back(s_sdata);
        s_sclk_prev = s_sclk;
        if (s_latch) s_lat_q.push_back(int'(s_row));
        if (s_done) s_done_q.push_back(cyc);
        if (!s_busy) s_busy_low++;
    end

    logic b_sclk_prev = 0;
    int b_rises = 0, b_row_rises = 0, b_lats = 0, b_ones = 0, b_hi_run = 0;
    int b_hi_min = 1000000, b_hi_max = 0, b_rr_min = 1000000, b_rr_max = 0;
    int b_done_q[$];
    always @(negedge clk) begin
        if (b_sclk && !b_sclk_prev) begin b_rises++; b_row_rises++; end
        if (b_sclk) b_hi_run++;
        else if (b_sclk_prev) begin
            if (b_hi_run < b_hi_min) b_hi_min = b_hi_run;
            if (b_hi_run > b_hi_max) b_hi_max = b_hi_run;
            b_hi_run = 0;
        end
        b_sclk_prev = b_sclk;
        if (b_sdata) b_ones++;
        if (b_latch) begin
            b_lats++;
            if (b_row_rises < b_rr_min) b_rr_min = b_row_rises;
            if (b_row_rises > b_rr_max) b_rr_max = b_row_rises;
            b_row_rises = 0;
        end
        if (b_done) b_done_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        s_rst = 1; s_start = 1; s_frame = '0;
        b_rst = 1; b_start = 0; b_frame = '0;
        fork
            begin : small_seq
                int k;
                logic [7:0] r0, r1;
                repeat (3) tick();
                chk("reset_outputs", {s_busy, s_done, s_sclk, s_sdata, s_latch, s_row}, 0);
                s_rst = 0; s_start = 0;
                tick();

                // fixed pattern A5 / 3C
                s_frame[0] = 8'hA5; s_frame[1] = 8'h3C;
                s_rise_q.delete(); s_lat_q.delete(); s_done_q.delete();
                s_start = 1; tick(); k = cyc; s_start = 0; s_busy_low = 0;
                for (int i = 0; i < 120 && s_done_q.size() < NDONE; i++) tick();
                chk("pattern_done_count", s_done_q.size(), NDONE);
                if (s_done_q.size() > 0) chk("pattern_done_latency", s_done_q[0] - k, 36);
                chk("pattern_rises", s_rise_q.size(), 16 * NDONE);
                if (s_rise_q.size() >= 16) begin
                    r0 = '0; r1 = '0;
                    for (int i = 0; i < 8; i++) r0 = {r0[6:0], s_rise_q[i]};
                    for (int i = 8; i < 16; i++) r1 = {r1[6:0], s_rise_q[i]};
                    chk("pattern_row0_bits", r0, 8'b10100101);
                    chk("pattern_row1_bits", r1, 8'b00111100);
                end
                chk("pattern_latches", s_lat_q.size(), 2 * NDONE);
                if (s_lat_q.size() >= 2) begin
                    chk("pattern_latch0_row", s_lat_q[0], 0);
                    chk("pattern_latch1_row", s_lat_q[1], 1);
                end
`ifdef SCAN_LOOP_EN
                if (s_done_q.size() >= 2) chk("loop_done_period", s_done_q[1] - s_done_q[0], 37);
                if (s_lat_q.size() >= 4) begin
                    chk("loop_latch2_row", s_lat_q[2], 0);
                    chk("loop_latch3_row", s_lat_q[3], 1);
                end
                chk("loop_busy_drops", s_busy_low, 0);
                s_rst = 1; tick(); s_rst = 0;
`endif

                // random frames, stray start pulses, mid-scan frame edits
                for (int it = 0; it < 12; it++) begin
                    s_frame[0] = 8'($urandom); s_frame[1] = 8'($urandom);
                    s_done_q.delete();
                    s_start = 1; tick(); k = cyc; s_start = 0;
                    for (int i = 0; i < 80 && s_done_q.size() == 0; i++) begin
                        s_start = (($urandom % 6) == 0);
                        if (($urandom % 16) == 0) s_frame[$urandom % 2] = 8'($urandom);
                        tick();
                    end
                    s_start = 0;
                    chk("random_done_seen", s_done_q.size(), 1);
                    if (s_done_q.size() > 0) chk("random_done_latency", s_done_q[0] - k, 36);
                    if (LOOP) begin s_rst = 1; tick(); s_rst = 0; end
                end

                // reset in the middle of row 1, bit 3
                tick();
                s_start = 1; tick(); s_start = 0;
                for (int i = 0; i < 100 && !(s_act && s_t == 25); i++) tick();
                chk("abort_row", s_row, 1);
                s_rst = 1; tick();
                chk("abort_outputs", {s_busy, s_done, s_sclk, s_sdata, s_latch, s_row}, 0);
                s_rst = 0;
                s_done_q.delete(); s_lat_q.delete();
                repeat (40) tick();
                chk("abort_no_done", s_done_q.size(), 0);
                chk("abort_no_latch", s_lat_q.size(), 0);
                s_start = 1; tick(); k = cyc; s_start = 0;
                chk("restart_row0", s_row, 0);
                for (int i = 0; i < 80 && s_done_q.size() == 0; i++) tick();
                chk("restart_done_seen", s_done_q.size(), 1);
                if (s_done_q.size() > 0) chk("restart_done_latency", s_done_q[0] - k, 36);
                if (s_lat_q.size() > 0) chk("restart_first_latch_row", s_lat_q[0], 0);
                s_rst = 1; tick(); s_rst = 0;
            end
            begin : big_seq
                int k;
                repeat (2) tick();
                b_rst = 0;
                b_start = 1; tick(); k = cyc; b_start = 0;
                for (int i = 0; i < B_D + 100 && b_done_q.size() == 0; i++) begin
                    b_start = (i == 500 || i == 41000 || i == 81990);
                    tick();
                end
                b_start = 0;
                chk("big_done_seen", b_done_q.size(), 1);
                if (b_done_q.size() > 0) chk("big_done_latency", b_done_q[0] - k, 82000);
                chk("big_sdata_ones", b_ones, 0);
                chk("big_latches", b_lats, 40);
                chk("big_total_rises", b_rises, 40 * 256);
                chk("big_row_rises_min", b_rr_min, 256);
                chk("big_row_rises_max", b_rr_max, 256);
                chk("big_sclk_high_min", b_hi_min, 4);
                chk("big_sclk_high_max", b_hi_max, 4);
                b_rst = 1; tick(); b_rst = 0;
            end
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
